tow_match_scorer: RTL and testbench

Parametrised successor to the single-round tug-of-war scorer. It tracks the rope position over a configurable number of positions per side, applies jump-the-light, fake-state and favour-the-loser rules, and counts round wins. A match is best-of-N rounds, with a timed hold between rounds and a latched match result. The block sits between the push arbiter (winrnd/right/tie) and the LED display driver.

---
 rtl/tow_match_scorer.sv | 155 +++++++++++++++
 tb/tb_tow_match_scorer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tow_match_scorer.sv
// Tug-of-war match scorer: tracks the rope position, applies the
// jump-the-light, fake-state and favour-the-loser rules, counts round wins
// and latches the match result once one side reaches ROUNDS_TO_WIN.
module tow_match_scorer #(
    parameter int SIDE_LEN      = 3,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int HOLD_CYCLES   = 8,
    parameter int FAVOUR_LOSER  = 1,
    localparam int SW = 2 * SIDE_LEN + 1,
    localparam int RW = $clog2(ROUNDS_TO_WIN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          winrnd,
    input  logic          right,
    input  logic          leds_on,
    input  logic          tie,
    input  logic          fake,
    output logic [SW-1:0] score,
    output logic          round_win_left,
    output logic          round_win_right,
    output logic [RW-1:0] rounds_left,
    output logic [RW-1:0] rounds_right,
    output logic          match_over,
    output logic          match_winner_right
);

    // Position width: signed, wide enough for +/-(SIDE_LEN+1).
    localparam int PW = $clog2(SIDE_LEN + 2) + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic signed [PW-1:0] P_EDGE = PW'(SIDE_LEN);
    localparam logic signed [PW-1:0] N_EDGE = -P_EDGE;
    localparam logic signed [PW-1:0] P_WIN  = PW'(SIDE_LEN + 1);
    localparam logic signed [PW-1:0] N_WIN  = -P_WIN;
    localparam logic [HW-1:0]        HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0]        ROUNDS_MAX = RW'(ROUNDS_TO_WIN);

    typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;

    state_t                 state_q, state_d;
    logic signed [PW-1:0]   pos_q, pos_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [RW-1:0]          rl_q, rl_d, rr_q, rr_d;
    logic                   pwl_q, pwl_d, pwr_q, pwr_d;

    logic                   proper;
    logic                   mr;
    logic                   to_centre;
    logic signed [PW-1:0]   step;
    logic signed [PW-1:0]   moved;
    logic                   win_right;
    int                     idx;

    // Registered state; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst) begin
            state_q <= PLAY;
            pos_q   <= '0;
            hold_q  <= '0;
            rl_q    <= '0;
            rr_q    <= '0;
            pwl_q   <= 1'b0;
            pwr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            hold_q  <= hold_d;
            rl_q    <= rl_d;
            rr_q    <= rr_d;
            pwl_q   <= pwl_d;
            pwr_q   <= pwr_d;
        end
    end

    // Candidate move for the current push: direction and 1- or 2-step size.
    always_comb begin
        proper    = leds_on & ~fake;
        // Lights off or fake state credits the opponent.
        mr        = right ? proper : ~proper;
        to_centre = (pos_q == N_EDGE && mr) || (pos_q == P_EDGE && !mr);
        step      = (FAVOUR_LOSER != 0 && proper && to_centre) ? PW'(2) : PW'(1);
        moved     = mr ? pos_q + step : pos_q - step;
    end

    // Next-state logic for PLAY / HOLD / OVER and round counting.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        pos_d   = pos_q;
        hold_d  = hold_q;
        rl_d    = rl_q;
        rr_d    = rr_q;
        pwl_d   = 1'b0;
        pwr_d   = 1'b0;
        case (state_q)
            PLAY: begin
                if (winrnd && !tie) begin
                    pos_d = moved;
                    if (moved == P_WIN) begin
                        pwr_d   = 1'b1;
                        rr_d    = (rr_q == ROUNDS_MAX) ? rr_q : rr_q + RW'(1);
                        state_d = (rr_q + RW'(1) == ROUNDS_MAX) ? OVER : HOLD;
                        hold_d  = '0;
                    end else if (moved == N_WIN) begin
                        pwl_d   = 1'b1;
                        rl_d    = (rl_q == ROUNDS_MAX) ? rl_q : rl_q + RW'(1);
                        state_d = (rl_q + RW'(1) == ROUNDS_MAX) ? OVER : HOLD;
                        hold_d  = '0;
                    end
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    pos_d   = '0;
                    hold_d  = '0;
                    state_d = PLAY;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    // Display decode: one-hot rope position in PLAY, winner's half otherwise.
    always_comb begin
        score     = '0;
        win_right = ~pos_q[PW-1];
        idx       = SIDE_LEN - int'(pos_q);
        for (int i = 0; i < SW; i++) begin
            if (state_q == PLAY) begin
                score[i] = (i == idx);
            end else begin
                score[i] = win_right ? (i < SIDE_LEN) : (i > SIDE_LEN);
            end
        end
    end

    assign round_win_left     = pwl_q;
    assign round_win_right    = pwr_q;
    assign rounds_left        = rl_q;
    assign rounds_right       = rr_q;
    assign match_over         = (state_q == OVER);
    assign match_winner_right = (state_q == OVER) & win_right;

endmodule

// File: tb/tb_tow_match_scorer.sv
// Scoreboard bench for tow_match_scorer: two configurations driven by the
// same stimulus, each checked every cycle against a behavioural model.
module tb_tow_match_scorer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, winrnd, right, leds_on, tie, fake;

    // Config A: defaults (SIDE_LEN=3, ROUNDS=2, HOLD=8, FAVOUR=1)
    logic [6:0] a_score;
    logic       a_rwl, a_rwr, a_over, a_win;
    logic [1:0] a_rl, a_rr;
    // Config B: SIDE_LEN=4, ROUNDS=3, HOLD=3, FAVOUR=0
    logic [8:0] b_score;
    logic       b_rwl, b_rwr, b_over, b_win;
    logic [1:0] b_rl, b_rr;

    tow_match_scorer dut_a (
        .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .leds_on(leds_on),
        .tie(tie), .fake(fake), .score(a_score), .round_win_left(a_rwl),
        .round_win_right(a_rwr), .rounds_left(a_rl), .rounds_right(a_rr),
        .match_over(a_over), .match_winner_right(a_win)
    );

    tow_match_scorer #(.SIDE_LEN(4), .ROUNDS_TO_WIN(3), .HOLD_CYCLES(3), .FAVOUR_LOSER(0)) dut_b (
        .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .leds_on(leds_on),
        .tie(tie), .fake(fake), .score(b_score), .round_win_left(b_rwl),
        .round_win_right(b_rwr), .rounds_left(b_rl), .rounds_right(b_rr),
        .match_over(b_over), .match_winner_right(b_win)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [31:0] score;
        logic        rwl, rwr;
        int          rl, rr;
        logic        over, win;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int c_side[2] = '{3, 4};
    int c_rtw[2]  = '{2, 3};
    int c_hold[2] = '{8, 3};
    int c_fav[2]  = '{1, 0};

    int m_pos[2];
    int m_rl[2];
    int m_rr[2];
    int m_hold[2];   // display cycles still to show after this one; 0 = playing
    bit m_over[2];
    bit m_pl[2];
    bit m_pr[2];

    function automatic logic [31:0] exp_score(input int side, input int pos, input bit playing);
        logic [31:0] band;
        band = (32'd1 << side) - 32'd1;
        if (playing) return 32'd1 << (side - pos);
        if (pos > 0) return band;
        return band << (side + 1);
    endfunction

    // Advance model d by one clock edge using the inputs sampled at that edge.
    task automatic model_edge(input int d);
        int  side;
        int  stp;
        bit  proper;
        bit  to_right;
        exp_t e;
        side = c_side[d];
        m_pl[d] = 1'b0;
        m_pr[d] = 1'b0;
        if (!rst) begin
            m_pos[d] = 0; m_rl[d] = 0; m_rr[d] = 0; m_hold[d] = 0; m_over[d] = 1'b0;
        end else if (m_over[d]) begin
            // match result latched
        end else if (m_hold[d] > 0) begin
            m_hold[d]--;
            if (m_hold[d] == 0) m_pos[d] = 0;
        end else if (winrnd && !tie) begin
            proper   = leds_on && !fake;
            to_right = right ? proper : !proper;
            stp = 1;
            if (c_fav[d] != 0 && proper && (m_pos[d] == side || m_pos[d] == -side)
                && ((m_pos[d] < 0) == to_right))
                stp = 2;
            m_pos[d] += to_right ? stp : -stp;
            if (m_pos[d] == side + 1) begin
                m_rr[d]++; m_pr[d] = 1'b1;
                if (m_rr[d] == c_rtw[d]) m_over[d] = 1'b1; else m_hold[d] = c_hold[d];
            end else if (m_pos[d] == -(side + 1)) begin
                m_rl[d]++; m_pl[d] = 1'b1;
                if (m_rl[d] == c_rtw[d]) m_over[d] = 1'b1; else m_hold[d] = c_hold[d];
            end
        end
        e.score = exp_score(side, m_pos[d], !m_over[d] && m_hold[d] == 0);
        e.rwl   = m_pl[d];
        e.rwr   = m_pr[d];
        e.rl    = m_rl[d];
        e.rr    = m_rr[d];
        e.over  = m_over[d];
        e.win   = m_over[d] && m_pos[d] > 0;
        if (d == 0) qa.push_back(e); else qb.push_back(e);
    endtask

    // ---------------- monitor ----------------
    exp_t ea, eb;
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            check("a.score", 32'(a_score), ea.score);
            check("a.round_win_left", 32'(a_rwl), 32'(ea.rwl));
            check("a.round_win_right", 32'(a_rwr), 32'(ea.rwr));
            check("a.rounds_left", 32'(a_rl), ea.rl);
            check("a.rounds_right", 32'(a_rr), ea.rr);
            check("a.match_over", 32'(a_over), 32'(ea.over));
            check("a.match_winner_right", 32'(a_win), 32'(ea.win));
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            check("b.score", 32'(b_score), eb.score);
            check("b.round_win_left", 32'(b_rwl), 32'(eb.rwl));
            check("b.round_win_right", 32'(b_rwr), 32'(eb.rwr));
            check("b.rounds_left", 32'(b_rl), eb.rl);
            check("b.rounds_right", 32'(b_rr), eb.rr);
            check("b.match_over", 32'(b_over), 32'(eb.over));
            check("b.match_winner_right", 32'(b_win), 32'(eb.win));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic w, input logic rt,
                        input logic l, input logic t, input logic f);
        rst = r; winrnd = w; right = rt; leds_on = l; tie = t; fake = f;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
    endtask

    task automatic push(input logic rt, input logic l, input logic f);
        step(1'b1, 1'b1, rt, l, 1'b0, f);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_push();
        push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        // Reset state
        do_reset();
        do_reset();
        check("reset.score", 32'(a_score), 32'b0001000);
        check("reset.rounds_right", 32'(a_rr), 32'd0);
        check("reset.match_over", 32'(a_over), 32'd0);

        // Four proper right pushes win a round
        push(1'b1, 1'b1, 1'b0); check("r1.score", 32'(a_score), 32'b0000100);
        push(1'b1, 1'b1, 1'b0); check("r2.score", 32'(a_score), 32'b0000010);
        push(1'b1, 1'b1, 1'b0); check("r3.score", 32'(a_score), 32'b0000001);
        push(1'b1, 1'b1, 1'b0); check("r4.score", 32'(a_score), 32'b0000111);
        check("r4.round_win_right", 32'(a_rwr), 32'd1);
        check("r4.rounds_right", 32'(a_rr), 32'd1);

        // Hold display lasts exactly 8 cycles; pushes ignored
        for (int i = 0; i < 7; i++) begin
            rand_push();
            check("hold.score", 32'(a_score), 32'b0000111);
        end
        check("hold.pulse_gone", 32'(a_rwr), 32'd0);
        push(1'b1, 1'b1, 1'b0);
        check("hold.recentred", 32'(a_score), 32'b0001000);

        // Tie ignored
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("tie.score", 32'(a_score), 32'b0001000);

        // Favour-the-loser 2-step
        do_reset();
        repeat (3) push(1'b0, 1'b1, 1'b0);
        check("left3.score", 32'(a_score), 32'b1000000);
        push(1'b1, 1'b1, 1'b0);
        check("favour.score", 32'(a_score), 32'b0010000);

        // No 2-step with FAVOUR_LOSER=0 (config B, SIDE_LEN=4)
        do_reset();
        repeat (4) push(1'b0, 1'b1, 1'b0);
        check("b.left4.score", 32'(b_score), 32'b100000000);
        push(1'b1, 1'b1, 1'b0);
        check("b.nofavour.score", 32'(b_score), 32'b010000000);

        // Fake push from the edge credits the opponent
        do_reset();
        repeat (3) push(1'b0, 1'b1, 1'b0);
        push(1'b1, 1'b1, 1'b1);
        check("fake.score", 32'(a_score), 32'b1110000);
        check("fake.round_win_left", 32'(a_rwl), 32'd1);

        // Jump-the-light and fake from centre
        do_reset();
        push(1'b1, 1'b0, 1'b0);
        check("jump.score", 32'(a_score), 32'b0010000);
        push(1'b0, 1'b1, 1'b1);
        check("fakeleft.score", 32'(a_score), 32'b0001000);

        // Match win and latched result
        do_reset();
        repeat (4) push(1'b1, 1'b1, 1'b0);
        repeat (8) idle();
        repeat (4) push(1'b1, 1'b1, 1'b0);
        check("match.over", 32'(a_over), 32'd1);
        check("match.winner_right", 32'(a_win), 32'd1);
        check("match.rounds_right", 32'(a_rr), 32'd2);
        for (int i = 0; i < 20; i++) begin
            rand_push();
            check("over.score", 32'(a_score), 32'b0000111);
        end
        do_reset();
        check("over.reset.score", 32'(a_score), 32'b0001000);
        check("over.reset.rounds", 32'(a_rr), 32'd0);
        check("over.reset.match_over", 32'(a_over), 32'd0);

        // Reset glitch between edges has no effect; reset across an edge does
        repeat (4) push(1'b1, 1'b1, 1'b0);
        repeat (2) idle();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        idle();
        check("glitch.score", 32'(a_score), 32'b0000111);
        check("glitch.rounds_right", 32'(a_rr), 32'd1);
        do_reset();
        check("edge_reset.score", 32'(a_score), 32'b0001000);
        check("edge_reset.rounds_right", 32'(a_rr), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 199) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 6) == 0));
        end

        #1;
        check("scoreboard.a_drained", 32'(qa.size()), 32'd0);
        check("scoreboard.b_drained", 32'(qb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
